// File: rtl/nv_strictsync_bus_hs.sv
// nv_strictsync_bus_hs
// Moves a WIDTH-bit word from the SRC_CLK domain to the DST_CLK domain with a
// toggle request/acknowledge handshake. The payload sits in a source-domain
// register that is held stable for the whole transfer. Only the single-bit
// req and ack toggles pass through SYNC_DEPTH-flop synchronisers.
module nv_strictsync_bus_hs #(
  parameter int WIDTH      = 8,
  parameter int SYNC_DEPTH = 3
) (
  input  logic             SRC_CLK,
  input  logic             SRC_CLRN,
  input  logic             DST_CLK,
  input  logic             DST_CLRN,
  input  logic             SRC_VALID,
  input  logic [WIDTH-1:0] SRC_DATA,
  output logic             SRC_READY,
  output logic             SRC_BUSY,
  output logic             DST_VALID,
  output logic [WIDTH-1:0] DST_DATA
);

  // Reject parameter values outside the supported ranges at elaboration.
  if (SYNC_DEPTH < 2 || SYNC_DEPTH > 4) begin : g_bad_sync_depth
    $error("nv_strictsync_bus_hs: SYNC_DEPTH must be in 2..4");
  end
  if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
    $error("nv_strictsync_bus_hs: WIDTH must be in 1..256");
  end

  // The source state is not stored separately: it is the XOR of the request
  // toggle and the synchronised acknowledge toggle.
  typedef enum logic {
    SRC_IDLE = 1'b0,
    SRC_XFER = 1'b1
  } src_state_e;

  // ---------------------------------------------------------------------
  // Source domain (SRC_CLK / SRC_CLRN)
  // ---------------------------------------------------------------------
  logic                  src_req_q;
  logic                  src_req_d;
  logic [WIDTH-1:0]      src_data_f_q;
  logic [WIDTH-1:0]      src_data_f_d;
  (* async_reg = "true" *)
  logic [SYNC_DEPTH-1:0] ack_sync_q;
  logic [SYNC_DEPTH-1:0] ack_sync_d;
  logic                  ack_sync;
  src_state_e            src_state;
  logic                  src_ready;

  // ---------------------------------------------------------------------
  // Destination domain (DST_CLK / DST_CLRN)
  // ---------------------------------------------------------------------
  (* async_reg = "true" *)
  logic [SYNC_DEPTH-1:0] req_sync_q;
  logic [SYNC_DEPTH-1:0] req_sync_d;
  logic                  req_s;
  logic                  dst_ack_q;
  logic                  dst_ack_d;
  logic                  dst_valid_q;
  logic                  dst_valid_d;
  logic [WIDTH-1:0]      dst_data_q;
  logic [WIDTH-1:0]      dst_data_d;

  // Source next-state: accept a word only in IDLE, then hold data and req.
  always_comb begin
    ack_sync     = ack_sync_q[SYNC_DEPTH-1];
    src_state    = src_state_e'(src_req_q ^ ack_sync);
    src_req_d    = src_req_q;
    src_data_f_d = src_data_f_q;
    src_ready    = 1'b0;
    ack_sync_d   = {ack_sync_q[SYNC_DEPTH-2:0], dst_ack_q};
    unique case (src_state)
      SRC_IDLE: begin
        src_ready = 1'b1;
        if (SRC_VALID) begin
          src_data_f_d = SRC_DATA;
          src_req_d    = ~src_req_q;
        end
      end
      SRC_XFER: begin
        // Offers are ignored until the acknowledge toggle comes back.
        src_ready = 1'b0;
      end
      default: begin
        src_ready = 1'b0;
      end
    endcase
  end

  // Source-domain registers, including the ack synchroniser chain.
  always_ff @(posedge SRC_CLK or negedge SRC_CLRN) begin
    if (!SRC_CLRN) begin
      src_req_q    <= 1'b0;
      src_data_f_q <= '0;
      ack_sync_q   <= '0;
    end else begin
      src_req_q    <= src_req_d;
      src_data_f_q <= src_data_f_d;
      ack_sync_q   <= ack_sync_d;
    end
  end

  // Destination next-state: a new req toggle captures the held source word
  // and raises DST_VALID for exactly one cycle.
  always_comb begin
    req_sync_d  = {req_sync_q[SYNC_DEPTH-2:0], src_req_q};
    req_s       = req_sync_q[SYNC_DEPTH-1];
    dst_ack_d   = dst_ack_q;
    dst_valid_d = 1'b0;
    dst_data_d  = dst_data_q;
    if (req_s != dst_ack_q) begin
      // src_data_f_q has been stable since before the toggle left the source.
      dst_data_d  = src_data_f_q;
      dst_ack_d   = req_s;
      dst_valid_d = 1'b1;
    end
  end

  // Destination-domain registers, including the req synchroniser chain.
  always_ff @(posedge DST_CLK or negedge DST_CLRN) begin
    if (!DST_CLRN) begin
      req_sync_q  <= '0;
      dst_ack_q   <= 1'b0;
      dst_valid_q <= 1'b0;
      dst_data_q  <= '0;
    end else begin
      req_sync_q  <= req_sync_d;
      dst_ack_q   <= dst_ack_d;
      dst_valid_q <= dst_valid_d;
      dst_data_q  <= dst_data_d;
    end
  end

  assign SRC_READY = src_ready;
  assign SRC_BUSY  = ~src_ready;
  assign DST_VALID = dst_valid_q;
  assign DST_DATA  = dst_data_q;

endmodule
